// File: rtl/midi_pkg.sv
// Shared MIDI status constants, state encodings and status-byte decode helpers
// used by the MIDI transmit path.
package midi_pkg;

  localparam logic [7:0] NOTE_OFF         = 8'h80;
  localparam logic [7:0] NOTE_ON          = 8'h90;
  localparam logic [7:0] POLY_PRESSURE    = 8'hA0;
  localparam logic [7:0] CONTROL_CHANGE   = 8'hB0;
  localparam logic [7:0] PROGRAM_CHANGE   = 8'hC0;
  localparam logic [7:0] CHANNEL_PRESSURE = 8'hD0;
  localparam logic [7:0] PITCH_BEND       = 8'hE0;
  localparam logic [7:0] SYSEX_START      = 8'hF0;
  localparam logic [7:0] MTC_QUARTER      = 8'hF1;
  localparam logic [7:0] SONG_POSITION    = 8'hF2;
  localparam logic [7:0] SONG_SELECT      = 8'hF3;
  localparam logic [7:0] SYS_RT_MIN       = 8'hF8;

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SEND} tx_state_e;
  typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic logic is_channel_status(input logic [7:0] status);
    return (status >= NOTE_OFF) && (status < SYSEX_START);
  endfunction

  function automatic logic is_system_common(input logic [7:0] status);
    return (status >= SYSEX_START) && (status < SYS_RT_MIN);
  endfunction

  // A status without bit7 set is an illegal input and is sent as a lone byte.
  function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd1;
    if (status[7]) begin
      case (status & 8'hF0)
        NOTE_OFF, NOTE_ON, POLY_PRESSURE, CONTROL_CHANGE, PITCH_BEND: len = 2'd3;
        PROGRAM_CHANGE, CHANNEL_PRESSURE:                             len = 2'd2;
        default: begin
          if (status == SONG_POSITION) len = 2'd3;
          else if ((status == MTC_QUARTER) || (status == SONG_SELECT)) len = 2'd2;
          else len = 2'd1;
        end
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/midi_tx_uart_byte.sv
// 8N1 byte serializer: a one-cycle load strobe starts a frame, done pulses on
// the edge that ends the stop bit. The line output is registered and idles high.
module midi_tx_uart_byte
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1536
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       txd_o,
  output logic       done_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          txd_q, txd_d;
  logic          baud_end;

  assign baud_end = (baud_q == BAUD_LAST);
  assign txd_o    = txd_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= UART_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
    end
  end

  // The line value is computed one cycle ahead so txd_q changes exactly on bit boundaries.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;
    done_o  = 1'b0;
    unique case (state_q)
      UART_IDLE: begin
        txd_d = 1'b1;
        if (load_i) begin
          state_d = UART_START;
          shreg_d = byte_i;
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = 1'b0;
        end
      end
      UART_START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = UART_DATA;
          txd_d   = shreg_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      UART_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      UART_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = UART_IDLE;
          done_o  = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = UART_IDLE;
    endcase
  end

endmodule

// File: rtl/midi_tx.sv
// MIDI OUT transmitter: accepts whole messages over valid/ready, applies
// running-status compression and sequences the bytes into the 8N1 serializer.
module midi_tx
  import midi_pkg::*;
#(
  parameter int CLK_FREQ          = 48_000_000,
  parameter int BAUD              = 31_250,
  parameter int CLKS_PER_BIT      = clks_per_bit(CLK_FREQ, BAUD),
  parameter bit RUNNING_STATUS_EN = 1'b1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] MSG_STATUS,
  input  logic [7:0] MSG_DATA1,
  input  logic [7:0] MSG_DATA2,
  input  logic       MSG_VALID,
  output logic       MSG_READY,
  input  logic       RS_FLUSH,
  output logic       MIDI_DOUT,
  output logic       TX_BUSY
);

  tx_state_e  state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [7:0] data1_q, data1_d;
  logic [7:0] data2_q, data2_d;
  logic [7:0] rs_q, rs_d;
  logic       rs_valid_q, rs_valid_d;
  logic [1:0] len_q, len_d;
  logic [1:0] idx_q, idx_d;
  logic       armed_q;
  logic       accept, rs_hit, byte_load, byte_done;
  logic [7:0] tx_byte;

  assign MSG_READY = (state_q == TX_IDLE) && armed_q;
  assign TX_BUSY   = (state_q != TX_IDLE);
  assign accept    = MSG_READY && MSG_VALID;

  // A flush in the accept cycle wins over the stored value, forcing the status out.
  assign rs_hit = RUNNING_STATUS_EN && is_channel_status(MSG_STATUS) &&
                  rs_valid_q && !RS_FLUSH && (rs_q == MSG_STATUS);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= TX_IDLE;
      status_q   <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
      rs_q       <= '0;
      rs_valid_q <= 1'b0;
      len_q      <= '0;
      idx_q      <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      rs_q       <= rs_d;
      rs_valid_q <= rs_valid_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      armed_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    rs_d       = rs_q;
    rs_valid_d = rs_valid_q && !RS_FLUSH;
    len_d      = len_q;
    idx_d      = idx_q;
    byte_load  = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (accept) begin
          state_d  = TX_LOAD;
          status_d = MSG_STATUS | 8'h80;
          data1_d  = MSG_DATA1;
          data2_d  = MSG_DATA2;
          len_d    = midi_msg_len(MSG_STATUS);
          idx_d    = rs_hit ? 2'd1 : 2'd0;
          if (is_channel_status(MSG_STATUS)) begin
            rs_d       = MSG_STATUS;
            rs_valid_d = 1'b1;
          end else if (is_system_common(MSG_STATUS)) begin
            rs_valid_d = 1'b0;
          end
        end
      end
      TX_LOAD: begin
        byte_load = 1'b1;
        state_d   = TX_SEND;
      end
      TX_SEND: begin
        if (byte_done) begin
          if (idx_q == (len_q - 2'd1)) begin
            state_d = TX_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = TX_LOAD;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_byte = status_q;
    if (idx_q == 2'd1) tx_byte = data1_q & 8'h7F;
    else if (idx_q == 2'd2) tx_byte = data2_q & 8'h7F;
  end

  midi_tx_uart_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_byte (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .load_i (byte_load),
    .byte_i (tx_byte),
    .txd_o  (MIDI_DOUT),
    .done_o (byte_done)
  );

endmodule

// File: tb/tb_midi_tx.sv
// Self-checking bench for midi_tx: a waveform-level model predicts the line,
// READY and BUSY every cycle, and a serial monitor decodes frames for literal checks.
module tb_midi_tx;

  localparam int CLK_FREQ = 125_000;
  localparam int BAUD     = 31_250;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * CPB + 1;
  localparam bit RS_EN    = 1'b1;

  logic       clk = 1'b0;
  logic       sysRst = 1'b1;
  logic [7:0] msgStatus = '0;
  logic [7:0] msgData1 = '0;
  logic [7:0] msgData2 = '0;
  logic       msgValid = 1'b0;
  logic       rsFlush = 1'b0;
  logic       msgReady, midiDout, txBusy;

  int checks = 0;
  int failures = 0;
  int cycCount = 0;
  int acceptCyc = 0;

  midi_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .CLKS_PER_BIT(CPB),
    .RUNNING_STATUS_EN(RS_EN)
  ) dut (
    .sys_clk(clk),
    .sys_rst(sysRst),
    .MSG_STATUS(msgStatus),
    .MSG_DATA1(msgData1),
    .MSG_DATA2(msgData2),
    .MSG_VALID(msgValid),
    .MSG_READY(msgReady),
    .RS_FLUSH(rsFlush),
    .MIDI_DOUT(midiDout),
    .TX_BUSY(txBusy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycCount++;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycCount);
    end
  endtask

  // Reference model: the expected line as a per-cycle bit queue.
  bit         lineQ[$];
  logic       expDout = 1'b1;
  logic       expReady = 1'b0;
  logic       expBusy = 1'b0;
  bit         armed = 1'b0;
  bit         modelAccepted = 1'b0;
  logic [7:0] rsVal = '0;
  bit         rsValid = 1'b0;

  function automatic int msgLen(input logic [7:0] s);
    if (s >= 8'h80 && s < 8'hC0) return 3;
    if (s >= 8'hC0 && s < 8'hE0) return 2;
    if (s >= 8'hE0 && s < 8'hF0) return 3;
    if (s == 8'hF2) return 3;
    if (s == 8'hF1 || s == 8'hF3) return 2;
    return 1;
  endfunction

  task automatic pushByte(input logic [7:0] b);
    lineQ.push_back(1'b1);
    repeat (CPB) lineQ.push_back(1'b0);
    for (int k = 0; k < 8; k++) repeat (CPB) lineQ.push_back(b[k]);
    repeat (CPB) lineQ.push_back(1'b1);
  endtask

  task automatic modelAccept();
    logic [7:0] s;
    int n;
    bit sendStatus;
    s = msgStatus;
    sendStatus = 1'b1;
    if (rsFlush) rsValid = 1'b0;
    if (!s[7]) begin
      pushByte(s | 8'h80);
      return;
    end
    n = msgLen(s);
    if (s < 8'hF0) begin
      if (RS_EN && rsValid && rsVal == s) sendStatus = 1'b0;
      rsVal = s;
      rsValid = 1'b1;
    end else if (s < 8'hF8) begin
      rsValid = 1'b0;
    end
    if (sendStatus) pushByte(s);
    if (n >= 2) pushByte(msgData1 & 8'h7F);
    if (n == 3) pushByte(msgData2 & 8'h7F);
  endtask

  always @(posedge clk or posedge sysRst) begin
    modelAccepted = 1'b0;
    if (sysRst) begin
      lineQ.delete();
      rsValid = 1'b0;
      armed = 1'b0;
    end else begin
      if (expReady && msgValid) begin
        modelAccepted = 1'b1;
        modelAccept();
      end else if (rsFlush) begin
        rsValid = 1'b0;
      end
      armed = 1'b1;
    end
    if (lineQ.size() > 0) begin
      expDout = lineQ.pop_front();
      expBusy = 1'b1;
      expReady = 1'b0;
    end else begin
      expDout = 1'b1;
      expBusy = 1'b0;
      expReady = armed;
    end
  end

  always @(negedge clk) begin
    checkOutput("dout", 32'(midiDout), 32'(expDout));
    checkOutput("ready", 32'(msgReady), 32'(expReady));
    checkOutput("busy", 32'(txBusy), 32'(expBusy));
  end

  // Serial monitor decoding frames from the line, sampling near the start of each bit.
  logic [7:0] rxQ[$];
  logic [7:0] expRx[$];
  bit         rxActive = 1'b0;
  int         rxOff = 0;
  logic [7:0] rxByte = '0;

  always @(negedge clk or posedge sysRst) begin
    if (sysRst) begin
      rxActive = 1'b0;
    end else if (!rxActive) begin
      if (midiDout === 1'b0) begin
        rxActive = 1'b1;
        rxOff = 0;
      end
    end else begin
      rxOff++;
      if (rxOff > CPB && rxOff < 9 * CPB && (rxOff % CPB) == 1)
        rxByte[(rxOff - 1) / CPB - 1] = midiDout;
      if (rxOff == 9 * CPB + 1) begin
        checkOutput("stop_bit", 32'(midiDout), 32'd1);
        rxQ.push_back(rxByte);
        rxActive = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2,
                               input bit keepValid, input bit flush);
    bit accepted;
    @(negedge clk);
    msgStatus = s;
    msgData1 = d1;
    msgData2 = d2;
    msgValid = 1'b1;
    rsFlush = flush;
    accepted = 1'b0;
    for (int i = 0; i < 3000 && !accepted; i++) begin
      @(posedge clk);
      #1;
      if (modelAccepted) accepted = 1'b1;
    end
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: status %0h never accepted", s);
    end
    acceptCyc = cycCount;
    rsFlush = 1'b0;
    if (!keepValid) msgValid = 1'b0;
  endtask

  task automatic waitReady(input int expElapsed, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (msgReady === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: READY got 0 expected 1 within 4000 cycles", name);
    end else if (expElapsed >= 0) begin
      checkOutput(name, 32'(cycCount - acceptCyc), 32'(expElapsed));
    end
  endtask

  task automatic checkRx(input string name);
    checkOutput({name, "_count"}, 32'(rxQ.size()), 32'(expRx.size()));
    for (int i = 0; i < expRx.size() && i < rxQ.size(); i++)
      checkOutput({name, "_byte"}, 32'(rxQ[i]), 32'(expRx[i]));
    rxQ.delete();
  endtask

  logic [7:0] pool [14] = '{8'h90, 8'h90, 8'h80, 8'hC5, 8'hD3, 8'hE0, 8'hF2,
                             8'hF1, 8'hF3, 8'hF8, 8'hFE, 8'hF0, 8'hF6, 8'hB2};

  initial begin
    int firstAccept;
    $display("[TB] start, CLKS_PER_BIT=%0d", CPB);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst_dout", 32'(midiDout), 32'd1);
    checkOutput("rst_ready", 32'(msgReady), 32'd0);
    checkOutput("rst_busy", 32'(txBusy), 32'd0);
    @(negedge clk);
    sysRst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ready_after_release", 32'(msgReady), 32'd1);

    // Basic three-byte note-on with exact start-bit timing.
    rxQ.delete();
    applyStimulus(8'h90, 8'h3C, 8'h64, 1'b0, 1'b0);
    checkOutput("load_dout", 32'(midiDout), 32'd1);
    checkOutput("load_busy", 32'(txBusy), 32'd1);
    checkOutput("load_ready", 32'(msgReady), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("start_dout", 32'(midiDout), 32'd0);
    waitReady(3 * FRAME, "t1_cycles");
    expRx = '{8'h90, 8'h3C, 8'h64};
    checkRx("t1");

    // Running status skips a repeated channel status.
    applyStimulus(8'h92, 8'h3C, 8'h64, 1'b0, 1'b0);
    waitReady(3 * FRAME, "t2a_cycles");
    expRx = '{8'h92, 8'h3C, 8'h64};
    checkRx("t2a");
    applyStimulus(8'h92, 8'h40, 8'h7F, 1'b0, 1'b0);
    waitReady(2 * FRAME, "t2b_cycles");
    expRx = '{8'h40, 8'h7F};
    checkRx("t2b");

    // Two-byte message, real-time in between does not disturb running status.
    applyStimulus(8'hC5, 8'h10, 8'hAA, 1'b0, 1'b0);
    waitReady(2 * FRAME, "t3a_cycles");
    expRx = '{8'hC5, 8'h10};
    checkRx("t3a");
    applyStimulus(8'hF8, 8'h00, 8'h00, 1'b0, 1'b0);
    waitReady(FRAME, "t3b_cycles");
    expRx = '{8'hF8};
    checkRx("t3b");
    applyStimulus(8'hC5, 8'h11, 8'h00, 1'b0, 1'b0);
    waitReady(FRAME, "t3c_cycles");
    expRx = '{8'h11};
    checkRx("t3c");

    // Data bit7 masking, then flush alone and flush coinciding with accept.
    applyStimulus(8'h90, 8'hFF, 8'h80, 1'b0, 1'b0);
    waitReady(3 * FRAME, "t4a_cycles");
    expRx = '{8'h90, 8'h7F, 8'h00};
    checkRx("t4a");
    @(negedge clk);
    rsFlush = 1'b1;
    @(negedge clk);
    rsFlush = 1'b0;
    applyStimulus(8'h90, 8'h01, 8'h02, 1'b0, 1'b0);
    waitReady(3 * FRAME, "t4b_cycles");
    expRx = '{8'h90, 8'h01, 8'h02};
    checkRx("t4b");
    applyStimulus(8'h90, 8'h05, 8'h06, 1'b0, 1'b1);
    waitReady(3 * FRAME, "t4c_cycles");
    expRx = '{8'h90, 8'h05, 8'h06};
    checkRx("t4c");

    // VALID held high across two different messages.
    applyStimulus(8'hB1, 8'h07, 8'h64, 1'b1, 1'b0);
    firstAccept = acceptCyc;
    applyStimulus(8'hE2, 8'h00, 8'h40, 1'b0, 1'b0);
    checkOutput("hold_accept_gap", 32'(acceptCyc - firstAccept), 32'(3 * FRAME + 1));
    waitReady(3 * FRAME, "hold_cycles");
    expRx = '{8'hB1, 8'h07, 8'h64, 8'hE2, 8'h00, 8'h40};
    checkRx("hold");

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk);
        rsFlush = 1'b1;
        @(negedge clk);
        rsFlush = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(pool[$urandom_range(0, 13)], 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    end
    waitReady(-1, "random_drain");
    rxQ.delete();

    // Asynchronous reset in the middle of a data bit.
    applyStimulus(8'h90, 8'h10, 8'h20, 1'b0, 1'b1);
    waitReady(3 * FRAME, "pre_rst_cycles");
    rxQ.delete();
    applyStimulus(8'h90, 8'h11, 8'h00, 1'b0, 1'b0);
    repeat (FRAME + 1 + 3 * CPB + 2) @(posedge clk);
    #1;
    checkOutput("pre_rst_dout", 32'(midiDout), 32'd0);
    #1;
    sysRst = 1'b1;
    #1;
    checkOutput("async_rst_dout", 32'(midiDout), 32'd1);
    checkOutput("async_rst_busy", 32'(txBusy), 32'd0);
    checkOutput("async_rst_ready", 32'(msgReady), 32'd0);
    repeat (3) @(negedge clk);
    sysRst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ready_after_rst", 32'(msgReady), 32'd1);
    rxQ.delete();
    applyStimulus(8'h90, 8'h01, 8'h02, 1'b0, 1'b0);
    waitReady(3 * FRAME, "post_rst_cycles");
    expRx = '{8'h90, 8'h01, 8'h02};
    checkRx("post_rst");

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/midi_tx.md
Name: midi_tx

Overview:
- Transmit-side counterpart of the MIDI receiver.
- Accepts complete MIDI channel, system-common and real-time messages over a valid/ready handshake.
- Serialises each message as 8N1 UART frames at 31250 baud on MIDI_DOUT.
- Applies optional running-status compression.
- Sits in the 48 MHz sys_clk domain alongside the MIDI receiver and the DDS/modulator path; drives a GPIO through the MIDI OUT opto/driver.

Parameters:
CLK_FREQ, 48000000, sys_clk frequency in Hz
BAUD, 31250, MIDI bit rate
CLKS_PER_BIT, CLK_FREQ/BAUD (1536), cycles per serial bit; must be at least 2
RUNNING_STATUS_EN, 1, 1 = omit a status byte that equals the last transmitted channel status

Ports:
sys_clk  in  1  system clock, 48 MHz
sys_rst  in  1  asynchronous reset, active-high
MSG_STATUS  in  8  status byte; bit7 is required to be 1
MSG_DATA1  in  8  first data byte; only bits [6:0] are transmitted
MSG_DATA2  in  8  second data byte; only bits [6:0] are transmitted
MSG_VALID  in  1  message present
MSG_READY  out  1  block can accept a message
RS_FLUSH  in  1  single-cycle pulse; forget running status so the next status byte is always sent
MIDI_DOUT  out  1  serial output, idle high
TX_BUSY  out  1  high while any frame of an accepted message is in flight

Behaviour:
- Clock and reset: single clock, sys_clk. Reset is asynchronous and active-high, named sys_rst.
- Reset values:
  - MIDI_DOUT=1, MSG_READY=0 while sys_rst is high, then 1 from the first clock after release.
  - TX_BUSY=0, running-status register cleared (invalid), FSM=IDLE, bit and baud counters cleared.
  - Reset mid-frame abandons the frame immediately; the line returns high asynchronously.
- Handshake:
  - A message is accepted on a rising edge with MSG_VALID && MSG_READY. Inputs are registered on that edge.
  - MSG_READY=1 only in IDLE.
  - MSG_VALID while busy is ignored and not queued. The source must hold it.
- Message length from the status byte (decode function in package):
  - 8x, 9x, Ax, Bx, Ex, F2: 3 bytes.
  - Cx, Dx, F1, F3: 2 bytes.
  - F0, F4–F7, F8–FF: 1 byte (SysEx payload is sent as raw one-byte messages).
- Running status (when RUNNING_STATUS_EN=1):
  - Channel status 80–EF equal to the stored value: the status byte is skipped.
  - Channel status 80–EF not equal to the stored value: the status byte is sent and stored.
  - F0–F7 clears the stored value.
  - F8–FF (real-time) neither uses nor alters it.
  - RS_FLUSH clears it. RS_FLUSH coinciding with acceptance takes effect before the skip decision, so the status byte is sent.
- FSM:
  - IDLE -> LOAD on accept.
  - LOAD (1 cycle): select the first byte to send, set TX_BUSY=1.
  - LOAD -> START -> DATA (8 bits, LSB first) -> STOP, each bit exactly CLKS_PER_BIT cycles.
  - STOP -> LOAD if bytes remain (no inter-byte gap beyond the 1 LOAD cycle), otherwise -> IDLE.
- Latency:
  - MIDI_DOUT falls 2 cycles after the accept edge (LOAD cycle, then start bit).
  - A frame is 10*CLKS_PER_BIT = 15360 cycles.
  - An n-byte message occupies n*(15360+1) cycles from LOAD to IDLE.
  - TX_BUSY falls and MSG_READY rises together on the edge that ends the last stop bit.
- Width rules: the baud counter is clog2(CLKS_PER_BIT) bits and wraps at CLKS_PER_BIT-1. The bit index is 3 bits.
- A status input with bit7=0 is treated as 1-byte, with bit7 forced to 1 on the line. This is an illegal-input guard only.

Decomposition:
- Package midi_pkg:
  - Status range constants (NOTE_OFF=8'h80 … SYS_RT_MIN=8'hF8).
  - Function midi_msg_len(status) returning 2-bit length.
  - Function is_channel_status(status).
  - Localparam CLKS_PER_BIT derivation.
- Sub-module midi_tx_uart_byte: start/stop/8-bit serializer with load/done strobes and baud counter.
- The top holds the message FSM, byte sequencing and running status.

Test Plan:
- Accept 0x90,0x3C,0x64 after reset -> three frames 0x90, 0x3C, 0x64, LSB first, 1536 cycles/bit, start low at accept+2, READY high after 3*15361 cycles.
- Repeat 0x92,0x40,0x7F after 0x92,0x3C,0x64 -> second message sends only 0x40, 0x7F (2 frames). With RUNNING_STATUS_EN=0 -> all 3 frames.
- 0xC5,0x10,0xAA -> frames 0xC5, 0x10 only, DATA2 ignored. Then 0xF8 -> single frame 0xF8. Then 0xC5,0x11 -> only 0x11 sent (running status survives real-time).
- 0x90,0xFF,0x80 -> data frames 0x7F, 0x00. Then RS_FLUSH and 0x90,0x01,0x02 -> status 0x90 resent.
- Hold MSG_VALID high continuously for 2 different messages -> second accepted only when READY=1, no frame corruption or gap beyond 1 cycle.
- Assert sys_rst mid-DATA of frame 2 -> MIDI_DOUT=1 within the reset cycle (asynchronous), READY=1 one clock after release, next 0x90 message sends its status byte.
